trigger_qualifier: RTL and testbench

- Parametrised multi-channel trigger front end; generalises the single-cycle OR-of-vector trigger decode.
- Adds per-channel enable mask, level/rising-edge qualification, programmable output pulse width, programmable re-arm holdoff, latched source-channel vector, and accepted/dropped event counters.
- Sits between the trigger-source logic and the acquisition start of the capture path.
- Drives trigger_start to the capture controller in the clk domain.

---
 rtl/trigger_pkg.sv | 15 +
 rtl/trigger_edge_qual.sv | 30 +++
 rtl/trigger_qualifier.sv | 132 +++++++++++++
 tb/tb_trigger_qualifier.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// Shared types and default widths for the trigger qualifier.
package trigger_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } trig_state_t;

    localparam int NUM_CH_DEF    = 4;
    localparam int PULSE_W_DEF   = 8;
    localparam int HOLDOFF_W_DEF = 16;
    localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/trigger_edge_qual.sv
// Per-channel level/rising-edge qualification with enable masking.
module trigger_edge_qual
    import trigger_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger_ready,
    input  logic [NUM_CH-1:0] trigger_vector,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              edge_mode,
    output logic [NUM_CH-1:0] qual_masked,
    output logic              hit
);

    logic [NUM_CH-1:0] prev_vec;
    logic [NUM_CH-1:0] qual;

    // Reset to 0 so a channel already high at reset release reads as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_vec <= '0;
        else     prev_vec <= trigger_vector;
    end

    assign qual        = edge_mode ? (trigger_vector & ~prev_vec) : trigger_vector;
    assign qual_masked = qual & ch_enable;
    assign hit         = trigger_ready & (|qual_masked);

endmodule

// File: rtl/trigger_qualifier.sv
// Multi-channel trigger front end: qualifies hits, emits a timed start pulse,
// enforces re-arm holdoff and counts accepted/dropped events.
//
//   state   | meaning
//   IDLE    | armed, waiting for a qualified hit
//   PULSE   | trigger_start high, counting down latched pulse width
//   HOLDOFF | trigger_start low, dead time before re-arming
module trigger_qualifier
    import trigger_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int PULSE_W   = PULSE_W_DEF,
    parameter int HOLDOFF_W = HOLDOFF_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger_ready,
    input  logic [NUM_CH-1:0]    trigger_vector,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic                 edge_mode,
    input  logic [PULSE_W-1:0]   pulse_cycles,
    input  logic [HOLDOFF_W-1:0] holdoff_cycles,
    output logic                 trigger_start,
    output logic [NUM_CH-1:0]    trigger_ch,
    output logic [CNT_W-1:0]     trigger_count,
    output logic [CNT_W-1:0]     dropped_count,
    output logic                 busy
);

    trig_state_t          state, state_n;
    logic [NUM_CH-1:0]    qual_masked;
    logic                 hit;
    logic                 accept, drop;
    logic                 pulse_last;
    logic [PULSE_W-1:0]   pulse_cnt;
    logic [HOLDOFF_W-1:0] hold_cnt;
    logic [HOLDOFF_W-1:0] hold_lat;

    trigger_edge_qual #(.NUM_CH(NUM_CH)) u_edge_qual (
        .clk            (clk),
        .rst            (rst),
        .trigger_ready  (trigger_ready),
        .trigger_vector (trigger_vector),
        .ch_enable      (ch_enable),
        .edge_mode      (edge_mode),
        .qual_masked    (qual_masked),
        .hit            (hit)
    );

    assign pulse_last = (pulse_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            trigger_start <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            trigger_start <= (state_n == PULSE);
            busy          <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    accept  = 1'b1;
                    state_n = PULSE;
                end
            end
            PULSE: begin
                if (!trigger_ready) begin
                    state_n = IDLE;
                end else if (pulse_last) begin
                    // Back-to-back re-trigger only when there is no dead time.
                    if (hold_lat == '0) begin
                        if (hit) accept  = 1'b1;
                        else     state_n = IDLE;
                    end else begin
                        drop    = hit;
                        state_n = HOLDOFF;
                    end
                end else begin
                    drop = hit;
                end
            end
            HOLDOFF: begin
                if (!trigger_ready) begin
                    state_n = IDLE;
                end else begin
                    drop = hit;
                    if (hold_cnt == '0) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trigger_ch    <= '0;
            trigger_count <= '0;
            dropped_count <= '0;
            pulse_cnt     <= '0;
            hold_cnt      <= '0;
            hold_lat      <= '0;
        end else begin
            if (accept) begin
                trigger_ch    <= qual_masked;
                trigger_count <= trigger_count + CNT_W'(1);
                pulse_cnt     <= (pulse_cycles == '0) ? '0 : pulse_cycles - PULSE_W'(1);
                hold_lat      <= holdoff_cycles;
            end else if (state == PULSE && !pulse_last) begin
                pulse_cnt <= pulse_cnt - PULSE_W'(1);
            end

            if (state == PULSE && state_n == HOLDOFF)
                hold_cnt <= hold_lat - HOLDOFF_W'(1);
            else if (state == HOLDOFF && hold_cnt != '0)
                hold_cnt <= hold_cnt - HOLDOFF_W'(1);

            if (drop && dropped_count != '1)
                dropped_count <= dropped_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_trigger_qualifier.sv
// Scoreboard bench for trigger_qualifier: stimulus pushes expected accept
// events, a negedge monitor pops and checks channel, count and pulse width.
module tb_trigger_qualifier;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger_ready;
    logic [3:0] trigger_vector;
    logic [3:0] ch_enable;
    logic       edge_mode;
    logic [7:0] pulse_cycles;
    logic [15:0] holdoff_cycles;
    logic       trigger_start;
    logic [3:0] trigger_ch;
    logic [7:0] trigger_count;
    logic [7:0] dropped_count;
    logic       busy;

    always #5 clk = ~clk;

    trigger_qualifier #(
        .NUM_CH(4), .PULSE_W(8), .HOLDOFF_W(16), .CNT_W(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trigger_ready  (trigger_ready),
        .trigger_vector (trigger_vector),
        .ch_enable      (ch_enable),
        .edge_mode      (edge_mode),
        .pulse_cycles   (pulse_cycles),
        .holdoff_cycles (holdoff_cycles),
        .trigger_start  (trigger_start),
        .trigger_ch     (trigger_ch),
        .trigger_count  (trigger_count),
        .dropped_count  (dropped_count),
        .busy           (busy)
    );

    typedef struct {
        logic [3:0] ch;
        logic [7:0] cnt;
        int         w;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [7:0] exp_drop = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] ch, input int w);
        exp_cnt = exp_cnt + 8'd1;
        q.push_back('{ch: ch, cnt: exp_cnt, w: w});
    endtask

    // Monitor: an accept event is start rising, or count changing while high.
    logic       prev_start = 1'b0;
    logic [7:0] prev_count = 8'd0;
    logic       run_active = 1'b0;
    int         run_len = 0;
    int         cur_w = 0;
    exp_t       e;

    always @(negedge clk) begin
        if (trigger_start === 1'b1 && (!prev_start || trigger_count != prev_count)) begin
            if (run_active) chk("pulse_width", run_len, cur_w);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_trigger ch=%b count=%0d t=%0t", trigger_ch, trigger_count, $time);
                run_active = 1'b0;
            end else begin
                e = q.pop_front();
                chk("trigger_ch", trigger_ch, e.ch);
                chk("trigger_count", trigger_count, e.cnt);
                cur_w      = e.w;
                run_len    = 1;
                run_active = 1'b1;
            end
        end else if (trigger_start === 1'b1) begin
            run_len++;
        end else if (run_active) begin
            chk("pulse_width", run_len, cur_w);
            run_active = 1'b0;
        end
        prev_start = (trigger_start === 1'b1);
        prev_count = trigger_count;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, trigger_start, 0);
        chk({tag, "_ch"}, trigger_ch, 0);
        chk({tag, "_count"}, trigger_count, 0);
        chk({tag, "_dropped"}, dropped_count, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        trigger_ready = 1'b0;
        trigger_vector = 4'b0000;
        ch_enable = 4'hF;
        edge_mode = 1'b0;
        pulse_cycles = 8'd1;
        holdoff_cycles = 16'd0;
        idle(3);
        chk_all_zero("reset");
        rst = 1'b0;
        trigger_ready = 1'b1;
        idle(2);

        // Level, pulse 1, holdoff 0: held vector gives continuous start.
        for (int t = 0; t < 8; t++) begin
            trigger_vector = (t < 5) ? 4'b0100 : 4'b0000;
            if (t < 5) push(4'b0100, 1);
            @(negedge clk);
        end
        chk("t1_count", trigger_count, 5);
        chk("t1_busy", busy, 0);

        // Edge, pulse 3, holdoff 4: single pulse, busy for 7 cycles.
        edge_mode = 1'b1;
        pulse_cycles = 8'd3;
        holdoff_cycles = 16'd4;
        idle(1);
        for (int t = 0; t < 9; t++) begin
            trigger_vector = 4'b0001;
            if (t == 0) push(4'b0001, 3);
            @(negedge clk);
            if (t == 6) chk("t2_busy_last", busy, 1);
            if (t == 7) chk("t2_busy_done", busy, 0);
        end
        chk("t2_count", trigger_count, exp_cnt);
        chk("t2_dropped", dropped_count, 0);
        trigger_vector = 4'b0000;
        idle(2);

        // Edge, pulse 2, holdoff 10: edge at t=5 dropped, t=13 accepted.
        pulse_cycles = 8'd2;
        holdoff_cycles = 16'd10;
        for (int t = 0; t < 27; t++) begin
            trigger_vector = (t == 0 || t == 5 || t == 13) ? 4'b0010 : 4'b0000;
            if (t == 0 || t == 13) push(4'b0010, 2);
            if (t == 5) exp_drop = exp_drop + 8'd1;
            @(negedge clk);
        end
        chk("t3_dropped", dropped_count, exp_drop);
        chk("t3_count", trigger_count, exp_cnt);
        chk("t3_busy", busy, 0);

        // Enable mask: ch0 masked off, ch1 passes.
        edge_mode = 1'b0;
        pulse_cycles = 8'd1;
        holdoff_cycles = 16'd0;
        ch_enable = 4'b1110;
        for (int t = 0; t < 6; t++) begin
            trigger_vector = (t < 3) ? 4'b0001 : ((t == 3) ? 4'b0011 : 4'b0000);
            if (t == 3) push(4'b0010, 1);
            @(negedge clk);
            if (t == 2) chk("t4_masked_start", trigger_start, 0);
        end
        ch_enable = 4'hF;

        // pulse_cycles 0 behaves as 1.
        pulse_cycles = 8'd0;
        for (int t = 0; t < 4; t++) begin
            trigger_vector = (t == 0) ? 4'b1000 : 4'b0000;
            if (t == 0) push(4'b1000, 1);
            @(negedge clk);
        end

        // Dropping ready mid-pulse ends it at once.
        edge_mode = 1'b1;
        pulse_cycles = 8'd20;
        holdoff_cycles = 16'd10;
        for (int t = 0; t < 9; t++) begin
            trigger_vector = 4'b0001;
            trigger_ready = (t == 5) ? 1'b0 : 1'b1;
            if (t == 0) push(4'b0001, 5);
            @(negedge clk);
            if (t == 5) begin
                chk("t5_ready_start", trigger_start, 0);
                chk("t5_ready_busy", busy, 0);
            end
        end
        chk("t5_dropped", dropped_count, exp_drop);

        // Async reset during holdoff; vector still high at release is an edge.
        pulse_cycles = 8'd2;
        for (int t = 0; t < 6; t++) begin
            trigger_vector = (t == 0) ? 4'b0000 : 4'b0001;
            if (t == 1) push(4'b0001, 2);
            @(negedge clk);
        end
        chk("t5_in_holdoff", busy, 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        exp_cnt = 8'd0;
        exp_drop = 8'd0;
        push(4'b0001, 2);
        @(negedge clk);
        rst = 1'b0;
        idle(14);
        chk("t5_post_rst_count", trigger_count, exp_cnt);
        trigger_vector = 4'b0000;
        idle(2);

        // Count wrap: 255 back-to-back accepts from 1 land on 0.
        edge_mode = 1'b0;
        pulse_cycles = 8'd1;
        holdoff_cycles = 16'd0;
        for (int t = 0; t < 258; t++) begin
            trigger_vector = (t < 255) ? 4'b0001 : 4'b0000;
            if (t < 255) push(4'b0001, 1);
            @(negedge clk);
        end
        chk("t6_wrap_model", trigger_count, exp_cnt);
        chk("t6_wrap_zero", trigger_count, 0);

        // Dropped saturation: 299 hits during pulse+holdoff.
        pulse_cycles = 8'd200;
        holdoff_cycles = 16'd100;
        for (int t = 0; t < 310; t++) begin
            trigger_vector = (t < 300) ? 4'b0001 : 4'b0000;
            if (t == 0) push(4'b0001, 200);
            @(negedge clk);
        end
        chk("t6_dropped_sat", dropped_count, 8'hFF);
        chk("t6_busy", busy, 0);

        idle(2);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
